// File: rtl/melay_sched_if.sv
// Bundle between the requesters, the scheduler and the shared serial detector.
// The master side is the environment (requesters plus detector) and the slave side is melay_sched.
interface melay_sched_if #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(FRAME_LEN + 1);

  logic [NREQ-1:0]           req;
  logic [NREQ*FRAME_LEN-1:0] data;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic                      det_rst;
  logic                      det_din;
  logic                      det_dout;
  logic                      done;
  logic [IDW-1:0]            done_id;
  logic [CNTW-1:0]           match_cnt;

  modport master (
    output req, data, det_dout,
    input  gnt, busy, det_rst, det_din, done, done_id, match_cnt
  );

  modport slave (
    input  req, data, det_dout,
    output gnt, busy, det_rst, det_din, done, done_id, match_cnt
  );
endinterface

// File: rtl/melay_sched.sv
// Scheduler that lets NREQ requesters share one serial Mealy detector: it grants a requester, shifts its frame in MSB-first and counts the dout pulses.
// Define MELAY_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module melay_sched #(
  parameter int NREQ      = 4,
  parameter int FRAME_LEN = 8
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  melay_sched_if.slave  bus
);
  localparam int IDW  = $clog2(NREQ);
  localparam int CNTW = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           r_state;
  logic [IDW-1:0]       r_cur_id;
  logic [FRAME_LEN-1:0] r_shreg;
  logic [CNTW-1:0]      r_bitcnt;
  logic [CNTW-1:0]      r_acc;
  logic [IDW-1:0]       r_done_id;
  logic [CNTW-1:0]      r_match_cnt;
`ifndef MELAY_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]       r_ptr;
`endif

  logic                 w_any;
  logic [IDW-1:0]       w_win;
  logic [CNTW-1:0]      w_acc_nxt;

  // Scan downward so the last hit, i.e. the first one at or after the start point, wins.
  always_comb begin
    int j;
    j     = 0;
    w_any = |bus.req;
    w_win = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef MELAY_SCHED_FIXED_PRIO_EN
      j = k;
`else
      j = int'(r_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
`endif
      if (bus.req[j]) w_win = IDW'(j);
    end
  end

  // The final SHIFT cycle's det_dout is folded straight into the reported count.
  assign w_acc_nxt = r_acc + CNTW'(bus.det_dout);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cur_id    <= '0;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_acc       <= '0;
      r_done_id   <= '0;
      r_match_cnt <= '0;
`ifndef MELAY_SCHED_FIXED_PRIO_EN
      r_ptr       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_cur_id <= w_win;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          r_shreg  <= bus.data[int'(r_cur_id)*FRAME_LEN +: FRAME_LEN];
          r_bitcnt <= '0;
          r_acc    <= '0;
          r_state  <= SHIFT;
        end
        SHIFT: begin
          r_shreg  <= {r_shreg[FRAME_LEN-2:0], 1'b0};
          r_bitcnt <= r_bitcnt + 1'b1;
          r_acc    <= w_acc_nxt;
          if (r_bitcnt == CNTW'(FRAME_LEN - 1)) begin
            r_done_id   <= r_cur_id;
            r_match_cnt <= w_acc_nxt;
            r_state     <= DONE;
          end
        end
        DONE: begin
`ifndef MELAY_SCHED_FIXED_PRIO_EN
          r_ptr   <= (r_cur_id == IDW'(NREQ - 1)) ? '0 : r_cur_id + 1'b1;
`endif
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = (r_state == GRANT) ? (NREQ'(1) << r_cur_id) : '0;
  assign bus.busy      = (r_state != IDLE);
  assign bus.det_rst   = (r_state == IDLE) || (r_state == GRANT);
  assign bus.det_din   = (r_state == SHIFT) && r_shreg[FRAME_LEN-1];
  assign bus.done      = (r_state == DONE);
  assign bus.done_id   = r_done_id;
  assign bus.match_cnt = r_match_cnt;
endmodule

// File: tb/tb_melay_sched.sv
// Directed bench for melay_sched with a behavioural non-overlapping "11" Mealy detector and a done scoreboard.
// Build with MELAY_SCHED_FIXED_PRIO_EN defined to check fixed-priority expectations.
module tb_melay_sched;
  localparam int NREQ = 4;
  localparam int FL   = 8;

  typedef struct {
    int id;
    int cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errs;
  exp_t q[$];
  logic det_st;

  melay_sched_if #(.NREQ(NREQ), .FRAME_LEN(FL)) bus ();

  melay_sched #(.NREQ(NREQ), .FRAME_LEN(FL)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector: synchronous active-high reset, dout = second '1' of a non-overlapping pair.
  always @(posedge clk) begin
    if (bus.det_rst) det_st <= 1'b0;
    else             det_st <= bus.det_din & ~det_st;
  end
  assign bus.det_dout = det_st & bus.det_din;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_cnt(input logic [FL-1:0] f);
    int c;
    logic st;
    c  = 0;
    st = 1'b0;
    for (int i = FL - 1; i >= 0; i--) begin
      if (st && f[i]) c++;
      st = f[i] & ~st;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(input int i, input logic [FL-1:0] f);
    bus.data[i*FL +: FL] = f;
  endtask

  task automatic push(input int id, input logic [FL-1:0] f);
    exp_t e;
    e.id  = id;
    e.cnt = exp_cnt(f);
    q.push_back(e);
  endtask

  task automatic wait_done(output int lat, output bit saw_din);
    lat     = 0;
    saw_din = 1'b0;
    do begin
      saw_din = saw_din | bus.det_din;
      tick();
      lat++;
    end while (!bus.done && lat < 40);
  endtask

  task automatic idle_for(input int n, output bit saw_busy);
    saw_busy = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      saw_busy = saw_busy | bus.busy;
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      n_checks++;
      assert (q.size() != 0) else begin
        n_errs++;
        $error("FAIL unexpected_done: got done_id %0d expected no done", bus.done_id);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("done_id", int'(bus.done_id), e.id);
        chk("match_cnt", int'(bus.match_cnt), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit saw;
    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.data = '0;

    // Reset values.
    #2;
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_det_din", int'(bus.det_din), 0);
    chk("rst_det_rst", int'(bus.det_rst), 1);
    chk("rst_done_id", int'(bus.done_id), 0);
    chk("rst_match_cnt", int'(bus.match_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // All-ones frame on requester 0.
    bus.req = 4'b0001;
    set_frame(0, 8'hFF);
    push(0, 8'hFF);
    tick();
    chk("t2_gnt", int'(bus.gnt), 1);
    chk("t2_det_rst_grant", int'(bus.det_rst), 1);
    chk("t2_busy", int'(bus.busy), 1);
    bus.req = '0;
    tick();
    chk("t2_det_rst_shift", int'(bus.det_rst), 0);
    chk("t2_det_din_first", int'(bus.det_din), 1);
    wait_done(lat, saw);
    chk("t2_done_latency", lat, 8);
    tick();
    chk("t2_idle_busy", int'(bus.busy), 0);
    chk("t2_hold_match_cnt", int'(bus.match_cnt), 4);

    // All-zeros frame on requester 2.
    bus.req = 4'b0100;
    set_frame(2, 8'h00);
    push(2, 8'h00);
    tick();
    chk("t3_gnt", int'(bus.gnt), 4);
    bus.req = '0;
    wait_done(lat, saw);
    chk("t3_done_latency", lat, 9);
    chk("t3_det_din_low", int'(saw), 0);
    tick();

    // Requester 1 drops req the cycle after its grant.
    bus.req = 4'b0010;
    set_frame(1, 8'h6E);
    push(1, 8'h6E);
    tick();
    chk("t5_gnt", int'(bus.gnt), 2);
    tick();
    bus.req = '0;
    wait_done(lat, saw);
    chk("t5_done_latency", lat, 8);
    idle_for(15, saw);
    chk("t5_stays_idle", int'(saw), 0);

    // Reset in the middle of SHIFT: no done must follow.
    bus.req = 4'b0001;
    set_frame(0, 8'hFF);
    tick();
    bus.req = '0;
    tick();
    tick();
    tick();
    chk("t1_busy_before", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_busy", int'(bus.busy), 0);
    chk("t1_det_rst", int'(bus.det_rst), 1);
    chk("t1_det_din", int'(bus.det_din), 0);
    chk("t1_gnt", int'(bus.gnt), 0);
    chk("t1_done_id", int'(bus.done_id), 0);
    chk("t1_match_cnt", int'(bus.match_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    idle_for(15, saw);
    chk("t1_no_activity", int'(saw), 0);

    // Full load: all four requesters held.
    set_frame(0, 8'hFF);
    set_frame(1, 8'h6E);
    set_frame(2, 8'h00);
    set_frame(3, 8'hB3);
`ifdef MELAY_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) push(0, 8'hFF);
`else
    push(0, 8'hFF);
    push(1, 8'h6E);
    push(2, 8'h00);
    push(3, 8'hB3);
    push(0, 8'hFF);
`endif
    bus.req = 4'b1111;
    wait_done(lat, saw);
    chk("t4_first_latency", lat, 10);
    for (int i = 0; i < 4; i++) begin
      wait_done(lat, saw);
      chk("t4_period", lat, 11);
    end
    bus.req = '0;
    tick();
    tick();

    // Two requesters held: 1 and 3.
`ifdef MELAY_SCHED_FIXED_PRIO_EN
    push(1, 8'h6E);
    push(1, 8'h6E);
    push(1, 8'h6E);
`else
    push(1, 8'h6E);
    push(3, 8'hB3);
    push(1, 8'h6E);
`endif
    bus.req = 4'b1010;
    wait_done(lat, saw);
    chk("t6_first_latency", lat, 10);
    for (int i = 0; i < 2; i++) begin
      wait_done(lat, saw);
      chk("t6_period", lat, 11);
    end
    bus.req = '0;
    tick();
    tick();
    tick();

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
